mips_run_ctrl: RTL

Parametrised run controller that sequences a MIPS core through reset, run and stop, replacing the fixed reset-release and fixed-duration stop of the current bench with a synthesizable block. It drives the core's reset and run enable, counts executed cycles, emits a per-N-cycle trace strobe, and terminates a run on core halt request, stuck PC, or cycle limit. The block sits between the bench (or board top) and the MIPS core and reports a completion code.

---
 rtl/mips_run_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences a MIPS core through reset, run and stop.
//   Holds the core in reset for RST_CYCLES edges after Start, then enables it
//   and counts run cycles. The run ends on a halt request, a PC that stays
//   unchanged for STUCK_CYCLES samples, or the MAX_CYCLES limit, in that
//   priority order. A completion code is reported and held until the next Start.
// Ports:
//   Clk, Reset     - clock and synchronous active-high reset
//   Start          - level-sampled run request (honoured in IDLE and DONE)
//   Halt_Req       - core halt request (syscall/break)
//   Pc             - core program counter
//   Cpu_Reset      - registered reset to the core
//   Cpu_Run        - registered run enable to the core
//   Cycle_Cnt      - run cycles executed
//   Trace_Stb      - one-cycle pulse every TRACE_EVERY run cycles
//   Done           - sticky completion flag
//   Done_Code      - 0 none, 1 halt, 2 stuck, 3 limit
module mips_run_ctrl #(
    parameter int unsigned RST_CYCLES   = 1,
    parameter int unsigned MAX_CYCLES   = 24,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PC_W         = 32,
    parameter int unsigned STUCK_CYCLES = 4,
    parameter int unsigned TRACE_EVERY  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt_Req,
    input  logic [PC_W-1:0]  Pc,
    output logic             Cpu_Reset,
    output logic             Cpu_Run,
    output logic [CNT_W-1:0] Cycle_Cnt,
    output logic             Trace_Stb,
    output logic             Done,
    output logic [1:0]       Done_Code
);

    localparam int unsigned HOLD_W  = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
    localparam int unsigned TRACE_W = (TRACE_EVERY > 1) ? $clog2(TRACE_EVERY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [HOLD_W-1:0]  hold_cnt,  hold_d;
    logic [TRACE_W-1:0] trace_cnt, trace_d;
    logic [CNT_W-1:0]   stuck_cnt, stuck_d;
    logic [PC_W-1:0]    pc_prev,   prev_d;
    logic               pc_valid,  valid_d;

    logic [CNT_W-1:0]   cnt_d;
    logic               stb_d, done_d, reset_d, run_d;
    logic [1:0]         code_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   stuck_inc;
    logic [1:0]         stop_code;

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            trace_cnt <= '0;
            stuck_cnt <= '0;
            pc_prev   <= '0;
            pc_valid  <= 1'b0;
            Cpu_Reset <= 1'b1;
            Cpu_Run   <= 1'b0;
            Cycle_Cnt <= '0;
            Trace_Stb <= 1'b0;
            Done      <= 1'b0;
            Done_Code <= 2'd0;
        end else begin
            state     <= next_state;
            hold_cnt  <= hold_d;
            trace_cnt <= trace_d;
            stuck_cnt <= stuck_d;
            pc_prev   <= prev_d;
            pc_valid  <= valid_d;
            Cpu_Reset <= reset_d;
            Cpu_Run   <= run_d;
            Cycle_Cnt <= cnt_d;
            Trace_Stb <= stb_d;
            Done      <= done_d;
            Done_Code <= code_d;
        end
    end

    // Next state, including stop detection for the current run edge
    always_comb begin
        cnt_inc   = Cycle_Cnt + 1'b1;
        // The stuck count used for the stop test is the value after this sample
        stuck_inc = (pc_valid && (Pc == pc_prev)) ? stuck_cnt + 1'b1 : '0;

        if (Halt_Req)
            stop_code = 2'd1;
        else if ((STUCK_CYCLES != 0) && (stuck_inc == CNT_W'(STUCK_CYCLES)))
            stop_code = 2'd2;
        else if (cnt_inc == CNT_W'(MAX_CYCLES))
            stop_code = 2'd3;
        else
            stop_code = 2'd0;

        next_state = state;
        case (state)
            S_IDLE:     if (Start) next_state = S_RST_HOLD;
            S_RST_HOLD: if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) next_state = S_RUN;
            S_RUN:      if (stop_code != 2'd0) next_state = S_DONE;
            S_DONE:     if (Start) next_state = S_RST_HOLD;
            default:    next_state = S_IDLE;
        endcase
    end

    // Next values of counters and registered outputs
    always_comb begin
        hold_d  = hold_cnt;
        trace_d = trace_cnt;
        stuck_d = stuck_cnt;
        prev_d  = pc_prev;
        valid_d = pc_valid;
        cnt_d   = Cycle_Cnt;
        stb_d   = 1'b0;
        done_d  = Done;
        code_d  = Done_Code;

        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    hold_d  = '0;
                    trace_d = '0;
                    stuck_d = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    code_d  = 2'd0;
                end
            end
            S_RST_HOLD: begin
                hold_d = hold_cnt + 1'b1;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (trace_cnt == TRACE_W'(TRACE_EVERY - 1)) begin
                    stb_d   = 1'b1;
                    trace_d = '0;
                end else begin
                    trace_d = trace_cnt + 1'b1;
                end
                stuck_d = stuck_inc;
                prev_d  = Pc;
                valid_d = 1'b1;
                if (stop_code != 2'd0) begin
                    done_d = 1'b1;
                    code_d = stop_code;
                end
            end
            default: ;
        endcase

        reset_d = (next_state == S_IDLE) || (next_state == S_RST_HOLD);
        run_d   = (next_state == S_RUN);
    end

endmodule
